regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_sb.sv | 112 +++++++++++
 tb/tb_regfile_sb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
// Holds the CLEAR/RUN state enum and the default parameter values.
package regfile_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam int DEF_DATAWIDTH  = 32;
  localparam int DEF_REGISTERS  = 32;
  localparam int DEF_READ_PORTS = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit array: one pending-write flag per register.
// Ports: clk, rst, en, clr/clr_addr, set/set_addr, ra in, rbusy out.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int REGISTERS  = DEF_REGISTERS,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int INDEX      = $clog2(REGISTERS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic [INDEX-1:0]            clr_addr,
  input  logic                        set,
  input  logic [INDEX-1:0]            set_addr,
  input  logic [READ_PORTS*INDEX-1:0] ra,
  output logic [READ_PORTS-1:0]       rbusy
);

  logic [REGISTERS-1:0] busy;

  // Set is applied after clear so a newly issued producer wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (en) begin
      if (clr)
        busy[clr_addr] <= 1'b0;
      if (set && set_addr != '0)
        busy[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    rbusy = '0;
    for (int p = 0; p < READ_PORTS; p++)
      rbusy[p] = busy[ra[p*INDEX +: INDEX]];
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with x0 hardwired, post-reset clear FSM and scoreboard.
// Ports: clk, rst, ready, werf/wa/wd, ra/rd/rbusy, sb_set/sb_addr.
// Define REGFILE_BYPASS_EN to forward wd to same-cycle reads of wa.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH  = DEF_DATAWIDTH,
  parameter int REGISTERS  = DEF_REGISTERS,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int INDEX      = $clog2(REGISTERS)
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            ready,
  input  logic                            werf,
  input  logic [INDEX-1:0]                wa,
  input  logic [DATAWIDTH-1:0]            wd,
  input  logic [READ_PORTS*INDEX-1:0]     ra,
  output logic [READ_PORTS*DATAWIDTH-1:0] rd,
  output logic [READ_PORTS-1:0]           rbusy,
  input  logic                            sb_set,
  input  logic [INDEX-1:0]                sb_addr
);

  state_t               state;
  state_t               state_n;
  logic [INDEX-1:0]     cnt;
  logic [INDEX-1:0]     cnt_n;
  logic [DATAWIDTH-1:0] regs [REGISTERS];
  logic                 run;
  logic                 wr_en;
  logic [READ_PORTS-1:0] busy_raw;

  assign run   = (state == RUN);
  assign ready = run;
  assign wr_en = run && werf && (wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= INDEX'(1);
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_n = cnt + INDEX'(1);
        if (cnt == INDEX'(REGISTERS-1))
          state_n = RUN;
      end
      RUN: begin
        state_n = RUN;
      end
      default: begin
        state_n = CLEAR;
      end
    endcase
  end

  // Entry 0 is never written; the read mux forces it to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run)
        regs[cnt] <= '0;
      else if (wr_en)
        regs[wa] <= wd;
    end
  end

  regfile_scoreboard #(
    .REGISTERS  (REGISTERS),
    .READ_PORTS (READ_PORTS),
    .INDEX      (INDEX)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .en       (run),
    .clr      (wr_en),
    .clr_addr (wa),
    .set      (sb_set),
    .set_addr (sb_addr),
    .ra       (ra),
    .rbusy    (busy_raw)
  );

  always_comb begin
    logic [INDEX-1:0] a;
    a     = '0;
    rd    = '0;
    rbusy = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      a = ra[p*INDEX +: INDEX];
      if (run && a != '0) begin
        rd[p*DATAWIDTH +: DATAWIDTH] = regs[a];
        rbusy[p] = busy_raw[p];
`ifdef REGFILE_BYPASS_EN
        if (werf && a == wa) begin
          rd[p*DATAWIDTH +: DATAWIDTH] = wd;
          rbusy[p] = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
// Table-driven RUN vectors plus clear, bypass and mid-clear sequences.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        werf;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        sb_set;
  logic [4:0]  sb_addr;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        werf;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sbs;
    logic [4:0]  sba;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t tv [15];

  regfile_sb dut (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .werf    (werf),
    .wa      (wa),
    .wd      (wd),
    .ra      (ra),
    .rd      (rd),
    .rbusy   (rbusy),
    .sb_set  (sb_set),
    .sb_addr (sb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic w, logic [4:0] a, logic [31:0] d,
    logic s, logic [4:0] sa,
    logic [4:0] r0, logic [4:0] r1,
    logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
    vec_t v;
    v.werf = w;  v.wa = a;   v.wd = d;
    v.sbs  = s;  v.sba = sa;
    v.r0   = r0; v.r1 = r1;
    v.e0   = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  task automatic drive(
    logic w, logic [4:0] a, logic [31:0] d,
    logic s, logic [4:0] sa,
    logic [4:0] r0, logic [4:0] r1);
    werf    = w;
    wa      = a;
    wd      = d;
    sb_set  = s;
    sb_addr = sa;
    ra      = {r1, r0};
  endtask

  task automatic chk(string nm, logic [31:0] e0,
                     logic [31:0] e1, logic [1:0] eb);
    n_vec++;
    if (rd[31:0] !== e0 || rd[63:32] !== e1 || rbusy !== eb) begin
      n_err++;
      $display("FAIL %s: rd0=%h rd1=%h rbusy=%b, want %h %h %b",
               nm, rd[31:0], rd[63:32], rbusy, e0, e1, eb);
    end
  endtask

  // Counts negedge samples with ready low after rst drops; also
  // confirms every lane reads 0 / not busy while clearing.
  task automatic count_clear(string nm);
    int n;
    int bad;
    bit ok;
    n = 0; bad = 0; ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (rd !== 64'h0 || rbusy !== 2'b00)
        bad++;
      n++;
    end
    n_vec++;
    if (!ok || n != 31) begin
      n_err++;
      $display("FAIL %s_len: ready low %0d cycles (done=%0b), want 31",
               nm, n, ok);
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s_lanes: %0d nonzero samples in CLEAR, want 0",
               nm, bad);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 1, 2, 0, 0, 2'b00);
    tv[1]  = mk(0, 0, 0, 0, 0, 5, 5,
                32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
    tv[2]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 5, 0,
                32'hDEADBEEF, 0, 2'b00);
    tv[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 2'b00);
    tv[5]  = mk(0, 0, 0, 1, 7, 7, 5, 0, 32'hDEADBEEF, 2'b00);
    tv[6]  = mk(0, 0, 0, 0, 0, 7, 7, 0, 0, 2'b11);
    tv[7]  = mk(1, 7, 32'h77, 0, 0, 5, 1,
                32'hDEADBEEF, 0, 2'b00);
    tv[8]  = mk(0, 0, 0, 0, 0, 7, 5,
                32'h77, 32'hDEADBEEF, 2'b00);
    tv[9]  = mk(1, 7, 32'h88, 1, 7, 5, 1,
                32'hDEADBEEF, 0, 2'b00);
    tv[10] = mk(0, 0, 0, 0, 0, 7, 7, 32'h88, 32'h88, 2'b11);
    tv[11] = mk(1, 31, 32'hA5A5A5A5, 1, 31, 7, 0,
                32'h88, 0, 2'b01);
    tv[12] = mk(0, 0, 0, 0, 0, 31, 7,
                32'hA5A5A5A5, 32'h88, 2'b11);
    tv[13] = mk(1, 31, 32'h1, 0, 0, 7, 30, 32'h88, 0, 2'b01);
    tv[14] = mk(0, 0, 0, 0, 0, 31, 31, 32'h1, 32'h1, 2'b00);

    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear("reset");
    step();

    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      @(negedge clk);
      chk($sformatf("clr_reg%0d", i), 0, 0, 2'b00);
      step();
    end

    for (int i = 0; i < 15; i++) begin
      drive(tv[i].werf, tv[i].wa, tv[i].wd,
            tv[i].sbs, tv[i].sba, tv[i].r0, tv[i].r1);
      @(negedge clk);
      chk($sformatf("vec%0d", i), tv[i].e0, tv[i].e1, tv[i].eb);
      step();
    end

    drive(1, 3, 32'h11, 1, 3, 3, 0);
    step();
    drive(1, 3, 32'h12345678, 0, 0, 3, 3);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("bypass", 32'h12345678, 32'h12345678, 2'b00);
`else
    chk("bypass", 32'h11, 32'h11, 2'b11);
`endif
    step();
    drive(0, 0, 0, 0, 0, 3, 0);
    @(negedge clk);
    chk("after_bypass", 32'h12345678, 0, 2'b00);
    step();

    drive(1, 9, 32'h99, 1, 9, 31, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear("midclr");
    werf   = 1'b0;
    sb_set = 1'b0;
    step();
    drive(0, 0, 0, 0, 0, 9, 3);
    @(negedge clk);
    chk("midclr_lost_wr", 0, 0, 2'b00);
    step();
    drive(0, 0, 0, 0, 0, 31, 1);
    @(negedge clk);
    chk("midclr_r31", 0, 0, 2'b00);
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
